md_sched_ctrl: RTL and testbench
================================

Name: md_sched_ctrl

Overview:
- Issue and hazard controller for the multiply/divide unit in the 5-stage MIPS pipeline.
- Watches the MD-class of the instructions in D and E, and issues the start pulse to the MD unit.
- Tracks each operation's latency in its own FSM and produces the D-stage stall.
- Suppresses issue on interrupt entry and eret.
- Sits between the controller decode outputs and the MD unit's start/busy pins.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (start edge to result-valid edge).
- DIV_CYCLES, 10, busy cycles for div/divu.
- CNT_W, 4, width of the latency counter; must satisfy 2**CNT_W > DIV_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, synchronous, active-high.
- md_op_d  in  4  MD class of the D-stage instruction.
- md_op_e  in  4  MD class of the E-stage instruction.
- int_req  in  1  interrupt taken this cycle; the E-stage instruction is flushed.
- eret  in  1  eret in E this cycle.
- md_start  out  1  one-cycle issue pulse to the MD unit.
- md_busy  out  1  operation in flight.
- md_done  out  1  one-cycle pulse; HI/LO valid from the next cycle.
- stall_d  out  1  freeze PC/D, bubble into E.

Behaviour:
- Class codes:
  - 0 mult, 1 multu, 2 div, 3 divu.
  - 4 mfhi, 5 mflo, 6 mthi, 7 mtlo.
  - 15 none.
  - Codes 8-14 are treated as none.
- FSM states:
  - IDLE -> MUL_RUN on issue of class 0/1.
  - IDLE -> DIV_RUN on issue of class 2/3.
  - MUL_RUN/DIV_RUN -> IDLE when the counter reaches limit-1.
- Issue rule: md_start is combinational and equals (state==IDLE) && md_op_e in {0..3} && !int_req && !eret.
- Counter:
  - Loads 0 on issue and increments each cycle in a RUN state.
  - Limit is MUL_CYCLES or DIV_CYCLES.
  - At limit-1: md_done=1 for that cycle (registered pulse), state returns to IDLE, counter clears.
- md_busy:
  - Registered.
  - 1 from the cycle after md_start through the md_done cycle inclusive.
  - Operation length is exactly MUL_CYCLES/DIV_CYCLES.
- stall_d = md_op_d in {0..7} && (md_busy || md_start) && !md_done.
  - Covers back-to-back MD instructions and mf/mt hazards.
  - md_done releases the stall one cycle early; the MD unit forwards HI/LO that cycle.
- E-stage MD ops never stall; they are issued or flushed.
- An E-stage mf/mt with busy cannot occur by construction; if it does, it is ignored and no assertion fires.
- int_req during RUN: the operation continues to completion (HI/LO is architectural state saved by the MD unit). stall_d still tracks busy.
- int_req and md_start candidate in the same cycle: int_req wins; no issue, state stays IDLE.
- eret behaves the same as int_req for issue suppression.
- clr:
  - Synchronous; overrides everything including mid-operation.
  - Next edge gives: state=IDLE, counter=0, md_busy=0, md_done=0.
  - md_start and stall_d fall combinationally, since state is IDLE and the inputs are flushed.
- Post-clr outputs are all 0.

Optional Feature:
- Macro: MD_SCHED_PERF_EN.
- When defined, adds output stall_cnt [31:0].
  - Counts clk cycles with stall_d=1.
  - Cleared by clr, saturates at 32'hFFFF_FFFF.
- When undefined, the port and counter are absent, with no other change.

Decomposition:
- Package md_sched_pkg holds:
  - class localparams MD_MULT..MD_MTLO and MD_NONE=4'hF;
  - FSM state encoding (IDLE=2'd0, MUL_RUN=2'd1, DIV_RUN=2'd2);
  - helper functions is_md_arith(op) and is_md_any(op).
- One sub-module: md_lat_counter.
  - Loadable up-counter with a limit input and terminal pulse.
  - Instantiated once.
  - The FSM and stall logic stay in the top.

Test Plan:
- Reset mid-div: issue div, assert clr at cycle 4 -> next edge md_busy=0, state IDLE, md_done never pulses.
- Mult issue: md_op_e=0 at t0 -> md_start=1 at t0; md_busy=1 t1..t5; md_done=1 at t5; busy=0 at t6.
- Div followed by mflo in D: md_op_e=2, md_op_d=5 at t0 -> stall_d=1 t0..t9, 0 at t10 (done cycle); 10-cycle occupancy.
- Interrupt collision: md_op_e=1 with int_req=1 -> md_start=0, md_busy stays 0; next cycle md_op_e=15, no issue.
- Back-to-back: mult in E, multu in D -> D stalls 5 cycles; multu issues the cycle after md_done; second md_done 5 cycles later.
- MD_SCHED_PERF_EN: the back-to-back case gives stall_cnt=5; after clr, stall_cnt=0.

Source files
------------

// File: rtl/md_sched_pkg.sv
// MD-class codes, FSM state encoding and class helpers shared by the MD scheduler.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package md_sched_pkg;

    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MFHI  = 4'd4;
    localparam logic [3:0] MD_MFLO  = 4'd5;
    localparam logic [3:0] MD_MTHI  = 4'd6;
    localparam logic [3:0] MD_MTLO  = 4'd7;
    localparam logic [3:0] MD_NONE  = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } md_state_e;

    // mult/multu/div/divu: the classes that occupy the MD unit
    function automatic logic is_md_arith(input logic [3:0] op);
        return (op <= MD_DIVU);
    endfunction

    // any class that touches HI/LO; codes 8-14 fall through as none
    function automatic logic is_md_any(input logic [3:0] op);
        return (op <= MD_MTLO);
    endfunction

endpackage

// File: rtl/md_sched_ctrl_if.sv
// Decode-side inputs and MD-unit/pipeline outputs of the MD scheduler.
// Latency: n/a (wiring only).
// Backpressure: stall_d is the only backpressure signal carried here.
interface md_sched_ctrl_if;

    logic [3:0]  md_op_d;
    logic [3:0]  md_op_e;
    logic        int_req;
    logic        eret;
    logic        md_start;
    logic        md_busy;
    logic        md_done;
    logic        stall_d;
`ifdef MD_SCHED_PERF_EN
    logic [31:0] stall_cnt;
`endif

    // pipeline/controller side
    modport master (
        output md_op_d, md_op_e, int_req, eret,
        input  md_start, md_busy, md_done, stall_d
`ifdef MD_SCHED_PERF_EN
      , input  stall_cnt
`endif
    );

    // scheduler side
    modport slave (
        input  md_op_d, md_op_e, int_req, eret,
        output md_start, md_busy, md_done, stall_d
`ifdef MD_SCHED_PERF_EN
      , output stall_cnt
`endif
    );

endinterface

// File: rtl/md_lat_counter.sv
// Loadable up-counter that pulses term_o during the cycle the count sits at limit-1.
// Latency: term_o is registered, raised one edge ahead from count==limit-2 (limit >= 2).
// Backpressure: none; en_i gates counting, clr_i and load_i restart it.
module md_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             term_q;
    logic             term_d;
    logic [CNT_W-1:0] lim_m1;
    logic [CNT_W-1:0] lim_m2;

    assign lim_m1 = limit_i - CNT_W'(1);
    assign lim_m2 = limit_i - CNT_W'(2);

    // next count and look-ahead terminal flag
    always_comb begin
        cnt_d  = cnt_q;
        term_d = 1'b0;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d  = (cnt_q == lim_m1) ? '0 : cnt_q + CNT_W'(1);
            term_d = (cnt_q == lim_m2);
        end
    end

    // counter and terminal pulse registers
    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q  <= '0;
            term_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

    assign term_o = term_q;

endmodule

// File: rtl/md_sched_ctrl.sv
// MD issue/hazard controller: issues md_start from E, tracks latency, stalls D on HI/LO hazards.
// Latency: md_start combinational; busy from next cycle for MUL_CYCLES/DIV_CYCLES; done on last busy cycle.
// Backpressure: stall_d freezes D while an MD op is issuing/running; MD_SCHED_PERF_EN adds stall_cnt.
module md_sched_ctrl
    import md_sched_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              clr,
    md_sched_ctrl_if.slave    bus
);

    localparam logic [CNT_W-1:0] MUL_LIM = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LIM = CNT_W'(DIV_CYCLES);

    md_state_e        state_q;
    md_state_e        state_d;
    logic             busy_q;
    logic             busy_d;
    logic             issue;
    logic             done;
    logic             running;
    logic [CNT_W-1:0] limit;

    // int_req/eret flush the E-stage op, so they veto issue
    assign issue   = (state_q == IDLE) && is_md_arith(bus.md_op_e)
                     && !bus.int_req && !bus.eret;
    assign running = (state_q != IDLE);
    assign limit   = (state_q == DIV_RUN) ? DIV_LIM : MUL_LIM;

    md_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat (
        .clk     (clk),
        .clr_i   (clr),
        .load_i  (issue),
        .en_i    (running),
        .limit_i (limit),
        .term_o  (done)
    );

    // next state: class bit 1 splits div/divu from mult/multu; done returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = bus.md_op_e[1] ? DIV_RUN : MUL_RUN;
                end
            end
            MUL_RUN, DIV_RUN: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // state and busy registers; clr aborts any op in flight
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.md_start = issue;
    assign bus.md_busy  = busy_q;
    assign bus.md_done  = done;
    // done releases D one cycle early: the MD unit forwards HI/LO in that cycle
    assign bus.stall_d  = is_md_any(bus.md_op_d) && (busy_q || issue) && !done;

`ifdef MD_SCHED_PERF_EN
    logic [31:0] stall_cnt_q;

    // saturating count of D-stall cycles
    always_ff @(posedge clk) begin
        if (clr) begin
            stall_cnt_q <= '0;
        end else if (bus.stall_d && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_md_sched_ctrl.sv
// Directed bench for md_sched_ctrl: per-cycle vectors with hand-computed {start,busy,done,stall}.
// Latency: inputs driven 1ns after posedge, outputs sampled mid-cycle.
// Backpressure: stall_d is checked as part of every vector.
module tb_md_sched_ctrl;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_fail;

    md_sched_ctrl_if bus_if();

    md_sched_ctrl #(
        .MUL_CYCLES (5),
        .DIV_CYCLES (10),
        .CNT_W      (4)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // drive one cycle of inputs, check {md_start,md_busy,md_done,stall_d} mid-cycle
    task automatic step(input string tag, input logic [3:0] d, input logic [3:0] e,
                        input logic ir, input logic er, input logic c, input logic [3:0] exp);
        bus_if.md_op_d = d;
        bus_if.md_op_e = e;
        bus_if.int_req = ir;
        bus_if.eret    = er;
        clr            = c;
        #4;
        chk(tag, {28'd0, bus_if.md_start, bus_if.md_busy, bus_if.md_done, bus_if.stall_d},
            {28'd0, exp});
        @(posedge clk);
        #1;
    endtask

    // idle cycle with clr asserted, no check
    task automatic do_clr();
        bus_if.md_op_d = 4'hF;
        bus_if.md_op_e = 4'hF;
        bus_if.int_req = 1'b0;
        bus_if.eret    = 1'b0;
        clr            = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr      = 1'b1;
        bus_if.md_op_d = 4'hF;
        bus_if.md_op_e = 4'hF;
        bus_if.int_req = 1'b0;
        bus_if.eret    = 1'b0;
        @(posedge clk);
        #1;
        do_clr();

        // reset state
        step("reset", 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000);
`ifdef MD_SCHED_PERF_EN
        chk("perf_reset", bus_if.stall_cnt, 32'd0);
`endif

        // mult: busy t1..t5, done t5; int_req at t2 does not abort it
        step("mul_t0", 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1000);
        for (int i = 1; i <= 4; i++)
            step($sformatf("mul_t%0d", i), 4'hF, 4'hF, (i == 2), 1'b0, 1'b0, 4'b0100);
        step("mul_t5", 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0110);
        step("mul_t6", 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000);

        // div with mflo in D: stall t0..t9, released at done (t10)
        step("div_t0", 4'h5, 4'h2, 1'b0, 1'b0, 1'b0, 4'b1001);
        for (int i = 1; i <= 9; i++)
            step($sformatf("div_t%0d", i), 4'h5, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0101);
        step("div_t10", 4'h5, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0110);
        step("div_t11", 4'hF, 4'h5, 1'b0, 1'b0, 1'b0, 4'b0000);

        // interrupt and eret collisions: no issue, no stall
        step("irq_multu", 4'hF, 4'h1, 1'b1, 1'b0, 1'b0, 4'b0000);
        step("irq_next", 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000);
        step("eret_divu", 4'h4, 4'h3, 1'b0, 1'b1, 1'b0, 4'b0000);
        step("code_9_e", 4'h6, 4'h9, 1'b0, 1'b0, 1'b0, 4'b0000);

        do_clr();
`ifdef MD_SCHED_PERF_EN
        chk("perf_after_clr1", bus_if.stall_cnt, 32'd0);
`endif

        // back-to-back mult then multu
        step("b2b_t0", 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1001);
        for (int i = 1; i <= 4; i++)
            step($sformatf("b2b_t%0d", i), 4'h1, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0101);
        step("b2b_t5", 4'h1, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0110);
        step("b2b_t6", 4'hF, 4'h1, 1'b0, 1'b0, 1'b0, 4'b1000);
        for (int i = 7; i <= 10; i++)
            step($sformatf("b2b_t%0d", i), 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0100);
        step("b2b_t11", 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0110);
        step("b2b_t12", 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000);
`ifdef MD_SCHED_PERF_EN
        chk("perf_b2b", bus_if.stall_cnt, 32'd5);
`endif

        // clr mid-div at cycle 4: busy drops next edge, done never pulses
        step("rdiv_t0", 4'hF, 4'h2, 1'b0, 1'b0, 1'b0, 4'b1000);
        for (int i = 1; i <= 3; i++)
            step($sformatf("rdiv_t%0d", i), 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0100);
        step("rdiv_t4_clr", 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 4'b0100);
`ifdef MD_SCHED_PERF_EN
        chk("perf_after_clr2", bus_if.stall_cnt, 32'd0);
`endif
        for (int i = 5; i <= 12; i++)
            step($sformatf("rdiv_t%0d", i), 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000);
        // a new mult still issues cleanly after the abort
        step("post_clr_mul", 4'h5, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
